// File: rtl/ocl_tile_config_regs.sv
// ============================================================================
// Module  : ocl_tile_config_regs
// Brief   : AXI-Lite responder for per-tile build info and runtime config.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ocl_tile_config_regs #(
  parameter int VERSION           = 10,
  parameter int N_TILES           = 1,
  parameter int TILE_ID           = 0,
  parameter int LOG_CQ_SLICE_SIZE = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [7:0]                   s_awaddr,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  input  logic [31:0]                  s_wdata,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  output logic [1:0]                   s_bresp,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  input  logic [7:0]                   s_araddr,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic [31:0]                  s_rdata,
  output logic [1:0]                   s_rresp,
  output logic [LOG_CQ_SLICE_SIZE:0]   cq_size,
  output logic [15:0]                  log_mask,
  output logic                         start,
  output logic                         running
);

  localparam int          CQW        = LOG_CQ_SLICE_SIZE + 1;
  localparam logic [31:0] CQ_MAX     = 32'(1) << LOG_CQ_SLICE_SIZE;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLV   = 2'b10;
  localparam logic [5:0]  A_VERSION  = 6'h00;
  localparam logic [5:0]  A_ID       = 6'h01;
  localparam logic [5:0]  A_CQ       = 6'h02;
  localparam logic [5:0]  A_MASK     = 6'h03;
  localparam logic [5:0]  A_CTRL     = 6'h04;
  localparam logic [5:0]  A_CYCLES   = 6'h05;
  localparam logic [15:0] C_TILE     = 16'(TILE_ID);
  localparam logic [15:0] C_NTILES   = 16'(N_TILES);

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  wstate_t            wstate_q;
  rstate_t            rstate_q;
  logic               aw_have_q, w_have_q, awready_q, wready_q, bvalid_q;
  logic [5:0]         awaddr_q;
  logic [31:0]        wdata_q;
  logic [1:0]         bresp_q, wresp_d;
  logic               arready_q, rvalid_q;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;
  logic [CQW-1:0]     cq_q, cq_d;
  logic [15:0]        mask_q, mask_d;
  logic               running_q, running_d, start_q, start_d;
  logic [31:0]        cycles_q, cycles_d;

  logic               w_aw_hs, w_w_hs, w_commit;
  logic [5:0]         w_waddr;
  logic [31:0]        w_wdata;
  logic               w_unused;

  assign w_aw_hs  = s_awvalid & awready_q;
  assign w_w_hs   = s_wvalid & wready_q;
  assign w_commit = (wstate_q == W_IDLE) & (aw_have_q | w_aw_hs) & (w_have_q | w_w_hs);
  // A channel captured on this very edge has not reached its holding register yet.
  assign w_waddr  = w_aw_hs ? s_awaddr[7:2] : awaddr_q;
  assign w_wdata  = w_w_hs ? s_wdata : wdata_q;
  assign w_unused = ^{s_awaddr[1:0], s_araddr[1:0]};

  always_comb begin
    cq_d      = cq_q;
    mask_d    = mask_q;
    running_d = running_q;
    start_d   = 1'b0;
    cycles_d  = running_q ? cycles_q + 32'd1 : cycles_q;
    wresp_d   = RESP_SLV;
    if (w_commit) begin
      case (w_waddr)
        A_CQ: begin
          wresp_d = RESP_OKAY;
          if (w_wdata == 32'd0)     cq_d = CQW'(1);
          else if (w_wdata > CQ_MAX) cq_d = CQ_MAX[CQW-1:0];
          else                       cq_d = w_wdata[CQW-1:0];
        end
        A_MASK: begin
          wresp_d = RESP_OKAY;
          mask_d  = w_wdata[15:0];
        end
        A_CTRL: begin
          wresp_d = RESP_OKAY;
          if (w_wdata[0]) begin
            running_d = 1'b1;
            cycles_d  = 32'd0;
            start_d   = 1'b1;
          end else if (w_wdata[1]) begin
            running_d = 1'b0;
          end
        end
        default: wresp_d = RESP_SLV;
      endcase
    end
  end

  always_comb begin
    rdata_d = 32'd0;
    rresp_d = RESP_OKAY;
    case (s_araddr[7:2])
      A_VERSION: rdata_d = 32'(VERSION);
      A_ID:      rdata_d = {C_TILE, C_NTILES};
      A_CQ:      rdata_d = 32'(cq_q);
      A_MASK:    rdata_d = {16'd0, mask_q};
      A_CTRL:    rdata_d = {31'd0, running_q};
      A_CYCLES:  rdata_d = cycles_q;
      default: begin
        rdata_d = 32'hDEADBEEF;
        rresp_d = RESP_SLV;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cq_q      <= CQ_MAX[CQW-1:0];
      mask_q    <= 16'd0;
      running_q <= 1'b0;
      start_q   <= 1'b0;
      cycles_q  <= 32'd0;
    end else begin
      cq_q      <= cq_d;
      mask_q    <= mask_d;
      running_q <= running_d;
      start_q   <= start_d;
      cycles_q  <= cycles_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      awaddr_q  <= 6'd0;
      wdata_q   <= 32'd0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (w_aw_hs) begin
            aw_have_q <= 1'b1;
            awaddr_q  <= s_awaddr[7:2];
            awready_q <= 1'b0;
          end
          if (w_w_hs) begin
            w_have_q <= 1'b1;
            wdata_q  <= s_wdata;
            wready_q <= 1'b0;
          end
          if (w_commit) begin
            wstate_q  <= W_RESP;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wresp_d;
          end
        end
        W_RESP: begin
          if (s_bready) begin
            wstate_q  <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (s_arvalid) begin
            rstate_q  <= R_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign cq_size   = cq_q;
  assign log_mask  = mask_q;
  assign start     = start_q;
  assign running   = running_q;

endmodule

`default_nettype wire

// File: tb/tb_ocl_tile_config_regs.sv
// ============================================================================
// Module  : tb_ocl_tile_config_regs
// Brief   : Self-checking bench with a register-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ocl_tile_config_regs;

  localparam int          L      = 10;
  localparam logic [31:0] CQ_MAX = 32'd1 << L;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_awvalid = 1'b0, s_awready;
  logic [7:0]  s_awaddr = 8'd0;
  logic        s_wvalid = 1'b0, s_wready;
  logic [31:0] s_wdata = 32'd0;
  logic        s_bvalid, s_bready = 1'b0;
  logic [1:0]  s_bresp;
  logic        s_arvalid = 1'b0, s_arready;
  logic [7:0]  s_araddr = 8'd0;
  logic        s_rvalid, s_rready = 1'b0;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic [L:0]  cq_size;
  logic [15:0] log_mask;
  logic        start, running;

  ocl_tile_config_regs #(
    .VERSION(10), .N_TILES(1), .TILE_ID(0), .LOG_CQ_SLICE_SIZE(L)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .cq_size(cq_size), .log_mask(log_mask), .start(start), .running(running)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; at a falling edge it names the edge just passed.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: register contents plus the edges of the last start and stop.
  logic [31:0] m_cq, m_mask;
  logic        m_run;
  int unsigned m_s, m_p;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cq = CQ_MAX; m_mask = 32'd0; m_run = 1'b0; m_s = 0; m_p = 0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input int unsigned k,
                             output logic [1:0] resp, output logic st);
    resp = 2'b10;
    st   = 1'b0;
    case (a[7:2])
      6'h02: begin resp = 2'b00; m_cq = (d == 0) ? 32'd1 : ((d > CQ_MAX) ? CQ_MAX : d); end
      6'h03: begin resp = 2'b00; m_mask = d & 32'h0000FFFF; end
      6'h04: begin
        resp = 2'b00;
        if (d[0]) begin m_run = 1'b1; m_s = k; st = 1'b1; end
        else if (d[1]) begin if (m_run) m_p = k; m_run = 1'b0; end
      end
      default: ;
    endcase
  endtask

  task automatic model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    resp = 2'b00;
    case (a[7:2])
      6'h00: d = 32'd10;
      6'h01: d = 32'h0000_0001;
      6'h02: d = m_cq;
      6'h03: d = m_mask;
      6'h04: d = {31'd0, m_run};
      6'h05: d = m_run ? (cyc - m_s) : (m_p - m_s);
      default: begin d = 32'hDEADBEEF; resp = 2'b10; end
    endcase
  endtask

  // lead > 0: AW goes |lead| cycles before W; lead < 0: W first; 0: together.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int lead, input int bdly);
    logic [1:0] er;
    logic       est;
    int         gap;
    gap = (lead < 0) ? -lead : lead;
    @(negedge clk);
    check("awready_idle", s_awready, 1);
    check("wready_idle", s_wready, 1);
    if (lead >= 0) begin s_awvalid = 1'b1; s_awaddr = a; end
    if (lead <= 0) begin s_wvalid = 1'b1; s_wdata = d; end
    if (gap > 0) begin
      @(negedge clk);
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      repeat (gap - 1) @(negedge clk);
      check("bvalid_early", s_bvalid, 0);
      if (lead > 0) begin
        check("awready_taken", s_awready, 0);
        s_wvalid = 1'b1; s_wdata = d;
      end else begin
        check("wready_taken", s_wready, 0);
        s_awvalid = 1'b1; s_awaddr = a;
      end
    end
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    model_write(a, d, cyc, er, est);
    check("bvalid", s_bvalid, 1);
    check("bresp", s_bresp, er);
    check("start", start, est);
    check("cq_size", cq_size, m_cq);
    check("log_mask", log_mask, m_mask);
    check("running", running, m_run);
    repeat (bdly) begin
      @(negedge clk);
      check("bvalid_hold", s_bvalid, 1);
      check("bresp_hold", s_bresp, er);
    end
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    check("bvalid_done", s_bvalid, 0);
    check("start_done", start, 0);
  endtask

  task automatic do_read(input logic [7:0] a, input int rdly);
    logic [31:0] ed;
    logic [1:0]  er;
    @(negedge clk);
    check("arready_idle", s_arready, 1);
    model_read(a, ed, er);
    s_arvalid = 1'b1; s_araddr = a;
    @(negedge clk);
    s_arvalid = 1'b0;
    check("rvalid", s_rvalid, 1);
    check("rdata", s_rdata, ed);
    check("rresp", s_rresp, er);
    repeat (rdly) begin
      @(negedge clk);
      check("rvalid_hold", s_rvalid, 1);
      check("rdata_hold", s_rdata, ed);
      check("arready_busy", s_arready, 0);
    end
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
    check("rvalid_done", s_rvalid, 0);
  endtask

  function automatic logic [7:0] rand_addr();
    int unsigned idx;
    idx = $urandom_range(0, 9);
    if (idx < 8)       return 8'(idx * 4) | 8'($urandom_range(0, 3));
    else if (idx == 8) return 8'h20;
    else               return 8'hFC;
  endfunction

  function automatic logic [31:0] rand_data(input logic [7:0] a);
    case (a[7:2])
      6'h02: case ($urandom_range(0, 4))
               0: return 32'd0;
               1: return CQ_MAX;
               2: return CQ_MAX + 32'd1;
               3: return 32'($urandom_range(1, 1023));
               default: return $urandom;
             endcase
      6'h04: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_awready", s_awready, 1);
    check("rst_wready", s_wready, 1);
    check("rst_arready", s_arready, 1);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_cq", cq_size, CQ_MAX);
    check("rst_mask", log_mask, 0);
    check("rst_start", start, 0);
    check("rst_running", running, 0);

    do_read(8'h00, 0);
    do_read(8'h04, 0);
    do_read(8'h08, 0);

    do_write(8'h08, 32'd0, 0, 0);    do_read(8'h08, 0);
    do_write(8'h08, 32'd5000, 0, 0); do_read(8'h08, 0);
    do_write(8'h08, 32'd300, 0, 1);  do_read(8'h08, 0);

    do_write(8'h0C, 32'h1234ABCD, 3, 0);
    do_write(8'h0C, 32'h00000000, 0, 0);
    do_write(8'h0C, 32'h1234ABCD, -3, 0);
    do_read(8'h0C, 0);

    do_write(8'h10, 32'd1, 0, 0);
    repeat (10) @(negedge clk);
    do_read(8'h14, 0);
    do_read(8'h10, 0);
    do_write(8'h10, 32'd3, 1, 0);
    repeat (4) @(negedge clk);
    do_read(8'h14, 0);
    do_write(8'h10, 32'd2, -1, 0);
    do_read(8'h14, 0);
    repeat (5) @(negedge clk);
    do_read(8'h14, 0);

    do_write(8'h14, 32'h55, 0, 0);
    do_write(8'h00, 32'h55, 0, 0);
    do_read(8'h20, 0);
    do_read(8'h04, 5);

    // Read and write of the same register on one edge: the read sees the old value.
    fork
      do_write(8'h0C, 32'h00005A5A, 0, 0);
      do_read(8'h0C, 0);
    join
    do_read(8'h0C, 0);

    do_write(8'h10, 32'd1, 0, 0);
    @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = 8'h0C;
    @(negedge clk);
    s_awvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_running", running, 0);
    check("async_rst_awready", s_awready, 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst2_bvalid", s_bvalid, 0);
    check("rst2_mask", log_mask, 0);
    check("rst2_awready", s_awready, 1);
    check("rst2_wready", s_wready, 1);
    check("rst2_arready", s_arready, 1);
    check("rst2_cq", cq_size, CQ_MAX);
    do_write(8'h0C, 32'h0000BEEF, -1, 0);
    do_read(8'h14, 0);

    for (int i = 0; i < 200; i++) begin
      logic [7:0] a;
      a = rand_addr();
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: do_write(a, rand_data(a), int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)));
        5, 6, 7:       do_read(a, int'($urandom_range(0, 2)));
        8: begin
          fork
            do_write(a, rand_data(a), 0, 0);
            do_read(rand_addr(), 0);
          join
        end
        default: repeat ($urandom_range(1, 4)) @(negedge clk);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
